// File: rtl/seg_scan_if.sv
// Load/display bus for the 7-segment scanner.
//   load_valid/load_ready/load_data : frame handshake (master offers, slave accepts)
//   dout        : shared segment bus (polarity already applied)
//   dnum        : digit enables (polarity already applied)
//   frame_start : 1-cycle pulse at the start of digit 0's slot
interface seg_scan_if #(
  parameter int DIGITS = 4,
  parameter int SEG_W  = 8
);
  logic                    load_valid;
  logic                    load_ready;
  logic [DIGITS*SEG_W-1:0] load_data;
  logic [SEG_W-1:0]        dout;
  logic [DIGITS-1:0]       dnum;
  logic                    frame_start;

  modport slave (
    input  load_valid, load_data,
    output load_ready, dout, dnum, frame_start
  );

  modport master (
    output load_valid, load_data,
    input  load_ready, dout, dnum, frame_start
  );
endinterface

// File: rtl/seg_scan_m.sv
// Time-multiplexed 7-segment scanner with a double-buffered frame.
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : seg_scan_if.slave
//          load_valid/load_ready/load_data - frame handshake, digit k at [k*SEG_W +: SEG_W]
//          dout        - segment bus (lit level set by DOUT_POL)
//          dnum        - one-hot digit enable while showing (active level set by DNUM_POL)
//          frame_start - pulse for the first tick of digit 0
// Each digit slot is PERIOD ticks: BLANK_CYC blank ticks first, then the digit is shown.
// A received frame waits in the shadow buffer and is copied to the active buffer only
// at the frame boundary, so a frame is never shown half old / half new.
module seg_scan_m #(
  parameter int DIGITS    = 4,
  parameter int SEG_W     = 8,
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1_000,
  parameter int BLANK_CYC = 500,
  parameter int DNUM_POL  = 1,
  parameter int DOUT_POL  = 1
) (
  input logic      clk,
  input logic      rst,
  seg_scan_if.slave bus
);

  localparam int PERIOD = CLK_HZ / SCAN_HZ;
  localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SEG_W-1:0]  DOUT_OFF = (DOUT_POL != 0) ? '0 : '1;
  localparam logic [DIGITS-1:0] DNUM_OFF = (DNUM_POL != 0) ? '0 : '1;

  typedef enum logic { BLANK = 1'b0, SHOW = 1'b1 } state_t;

  typedef logic [DIGITS-1:0][SEG_W-1:0] frame_t;

  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [DIG_W-1:0]  digit;
  frame_t            active;
  frame_t            shadow;
  logic              pending;

  logic              tick_wrap;
  logic              last_digit;
  logic [DIGITS-1:0] sel;
  logic [SEG_W-1:0]  seg_now;

  assign tick_wrap  = (tick == TICK_W'(PERIOD - 1));
  assign last_digit = (digit == DIG_W'(DIGITS - 1));
  assign seg_now    = active[digit];

  // one-hot select of the current digit
  for (genvar g = 0; g < DIGITS; g++) begin : g_sel
    assign sel[g] = (digit == DIG_W'(g));
  end

  // pending is a register, so ready is glitch-free
  assign bus.load_ready = ~pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= BLANK;
      tick            <= '0;
      digit           <= '0;
      active          <= '0;
      shadow          <= '0;
      pending         <= 1'b0;
      bus.dout        <= DOUT_OFF;
      bus.dnum        <= DNUM_OFF;
      bus.frame_start <= 1'b0;
    end else begin
      // outputs describe the tick that this edge ends
      case (state)
        BLANK: begin
          bus.dout <= DOUT_OFF;
          bus.dnum <= DNUM_OFF;
        end
        SHOW: begin
          bus.dout <= (DOUT_POL != 0) ? seg_now : ~seg_now;
          bus.dnum <= (DNUM_POL != 0) ? sel : ~sel;
        end
        default: begin
          bus.dout <= DOUT_OFF;
          bus.dnum <= DNUM_OFF;
        end
      endcase
      bus.frame_start <= (tick == '0) && (digit == '0);

      // slot counter and per-slot phase
      if (tick_wrap) begin
        tick  <= '0;
        digit <= last_digit ? '0 : digit + 1'b1;
        state <= BLANK;
      end else begin
        tick <= tick + 1'b1;
        if (tick == TICK_W'(BLANK_CYC - 1)) state <= SHOW;
      end

      // Swap wins over accept; both cannot happen together since ready=0 while pending.
      // An accept on a boundary with nothing pending waits for the next boundary.
      if (tick_wrap && last_digit && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (bus.load_valid && !pending) begin
        shadow  <= bus.load_data;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_m.sv
module tb_seg_scan_m;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(4), .SEG_W(8)) ifa ();
  seg_scan_if #(.DIGITS(4), .SEG_W(8)) ifb ();

  seg_scan_m #(.DIGITS(4), .SEG_W(8), .CLK_HZ(100), .SCAN_HZ(10), .BLANK_CYC(2),
               .DNUM_POL(1), .DOUT_POL(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  seg_scan_m #(.DIGITS(4), .SEG_W(8), .CLK_HZ(100), .SCAN_HZ(10), .BLANK_CYC(2),
               .DNUM_POL(0), .DOUT_POL(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  localparam logic [31:0] F_S2 = 32'h065B_4F66;
  localparam logic [31:0] F_A  = 32'h3F06_5B4F;
  localparam logic [31:0] F_B  = 32'h6D7D_077F;
  localparam logic [31:0] F_C  = 32'h6F77_7C39;
  localparam logic [31:0] F_D  = 32'h5E79_7100;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;   // rising edges since reset release
  bit mon_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, expv, k);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    ifa.load_valid = v;
    ifb.load_valid = v;
    ifa.load_data  = d;
    ifb.load_data  = d;
  endtask

  task automatic adv();
    @(negedge clk);
    k++;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] xd, input logic [3:0] xn,
                         input logic xf);
    logic [7:0] nd;
    logic [3:0] nn;
    nd = ~xd;
    nn = ~xn;
    chk({tag, "_dout"},  {24'h0, ifa.dout},        {24'h0, xd});
    chk({tag, "_dnum"},  {28'h0, ifa.dnum},        {28'h0, xn});
    chk({tag, "_fs"},    {31'h0, ifa.frame_start}, {31'h0, xf});
    chk({tag, "_doutN"}, {24'h0, ifb.dout},        {24'h0, nd});
    chk({tag, "_dnumN"}, {28'h0, ifb.dnum},        {28'h0, nn});
    chk({tag, "_fsN"},   {31'h0, ifb.frame_start}, {31'h0, xf});
  endtask

  task automatic chk_rdy(input string tag, input logic xr);
    chk({tag, "_rdy"},  {31'h0, ifa.load_ready}, {31'h0, xr});
    chk({tag, "_rdyN"}, {31'h0, ifb.load_ready}, {31'h0, xr});
  endtask

  // After k edges the outputs describe tick index k-1: slot (k-1)/10, tick (k-1)%10.
  task automatic check_k(input logic [31:0] frame, input string tag);
    int s, t, d;
    logic [7:0] xd;
    logic [3:0] xn;
    s  = k - 1;
    t  = s % 10;
    d  = (s / 10) % 4;
    xd = 8'h00;
    xn = 4'h0;
    if (t >= 2) begin
      xd = frame[d*8 +: 8];
      xn = 4'(1 << d);
    end
    chk_all(tag, xd, xn, (s % 40) == 0);
  endtask

  task automatic run_chk(input int upto, input logic [31:0] frame, input string tag);
    while (k < upto) begin
      adv();
      check_k(frame, tag);
    end
  endtask

  // slot shape: never two digits at once, segments dark whenever no digit is enabled
  always @(negedge clk) begin
    if (mon_en && rst) begin
      n_tests++;
      assert ($onehot0(ifa.dnum)) else begin
        n_fail++;
        $error("FAIL mon_onehot observed=%0h expected=onehot0", ifa.dnum);
      end
      if (ifa.dnum == 4'h0) begin
        n_tests++;
        assert (ifa.dout === 8'h00) else begin
          n_fail++;
          $error("FAIL mon_blank_dout observed=%0h expected=0", ifa.dout);
        end
      end
    end
  end

  initial begin
    drive(1'b0, 32'h0);

    // reset state
    #12;
    chk_all("rst", 8'h00, 4'h0, 1'b0);
    chk_rdy("rst", 1'b1);
    @(negedge clk);
    rst    = 1'b1;
    k      = 0;
    mon_en = 1'b1;

    // 1: idle frame of blanks, enable walking 0001..1000, frame_start every 40
    run_chk(40, 32'h0, "s1_idle");

    // 2: load during digit 1, shown only after the wrap
    run_chk(52, 32'h0, "s2_pre");
    drive(1'b1, F_S2);
    adv();
    check_k(32'h0, "s2_acc");
    chk_rdy("s2_drop", 1'b0);
    drive(1'b0, 32'h0);
    run_chk(79, 32'h0, "s2_old");
    chk_rdy("s2_hold", 1'b0);
    run_chk(80, 32'h0, "s2_old");
    chk_rdy("s2_back", 1'b1);
    run_chk(120, F_S2, "s2_new");

    // 3: A then B back-to-back with valid held
    drive(1'b1, F_A);
    adv();
    check_k(F_S2, "s3_accA");
    chk_rdy("s3_A_taken", 1'b0);
    drive(1'b1, F_B);
    run_chk(159, F_S2, "s3_wait");
    chk_rdy("s3_B_stall", 1'b0);
    adv();
    check_k(F_S2, "s3_swapA");
    chk_rdy("s3_swapA", 1'b1);
    adv();
    check_k(F_A, "s3_accB");
    chk_rdy("s3_B_taken", 1'b0);
    drive(1'b0, 32'h0);
    run_chk(200, F_A, "s3_showA");
    run_chk(239, F_B, "s3_showB");

    // accept on the wrap edge with nothing pending: held one full frame
    drive(1'b1, F_C);
    adv();
    check_k(F_B, "s3_wrapacc");
    chk_rdy("s3_wrap_held", 1'b0);
    drive(1'b0, 32'h0);
    run_chk(280, F_B, "s3_stillB");
    run_chk(285, F_C, "s3_showC");

    // 5: reset during digit 2 SHOW with frame D pending
    drive(1'b1, F_D);
    adv();
    check_k(F_C, "s5_accD");
    chk_rdy("s5_pendD", 1'b0);
    drive(1'b0, 32'h0);
    run_chk(306, F_C, "s5_pre");
    #2;
    rst = 1'b0;
    #1;
    chk_all("s5_async", 8'h00, 4'h0, 1'b0);
    chk_rdy("s5_async", 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    k   = 0;
    run_chk(80, 32'h0, "s5_post");
    chk_rdy("s5_post", 1'b1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard stop so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
